buffered_serializer: RTL and testbench
======================================

# buffered_serializer

Parametrised, double-buffered parallel-to-serial converter for the UART transmit path. It accepts words through a valid/ready handshake into a holding register, shifts them out one bit per `Ser_En` strobe, and supports runtime LSB-first or MSB-first order. Back-to-back words are sent with no idle bit between them. The UART TX frame FSM drives it and adds start, parity and stop bits around `Ser_Data`.

## Interface
- `P_DATA_WIDTH`, default 8: data word width; legal range 2..32.
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `P_Data` in `P_DATA_WIDTH`: parallel word.
- `Msb_First` in 1: bit order for the word; sampled with `P_Data` on accept.
- `Data_Valid` in 1: `P_Data`/`Msb_First` valid.
- `Data_Ready` out 1: holding register empty; the word is accepted when `Data_Valid && Data_Ready`.
- `Ser_En` in 1: bit strobe (baud tick); tie high for one bit per clock.
- `Ser_Data` out 1: serial bit, registered; idle value 1.
- `Ser_Active` out 1: `Ser_Data` currently carries a data bit.
- `Finish` out 1: one-cycle pulse after the last bit of a word completes.

## Operation
- Holding stage: `hold_reg`, `hold_msb`, `hold_full`. `Data_Ready = !hold_full`; it does not depend on `Data_Valid`. `Data_Valid` while not ready is ignored.
- Shift stage: `shift_reg`, `cur_msb`, `bit_cnt` (`$clog2(P_DATA_WIDTH)` bits) and `active`.
- FSM states:
  - IDLE (`active=0`)
  - SHIFT (`active=1`)
- Transitions are evaluated only in cycles with `Ser_En=1`. With `Ser_En=0`, only the holding stage may change.
  - IDLE & `hold_full`: load `shift_reg` and `cur_msb` from the holding stage, clear `hold_full`, set `bit_cnt=0`, go to SHIFT, and set `Ser_Data` to bit 0 (LSB-first) or bit W-1 (MSB-first).
  - SHIFT & `bit_cnt != W-1`: shift toward the output end, `bit_cnt++`, `Ser_Data` takes the next bit.
  - SHIFT & `bit_cnt == W-1`: pulse `Finish`.
    - If `hold_full`: load the next word exactly as from IDLE and stay in SHIFT (no gap).
    - Otherwise: go to IDLE with `Ser_Data=1`.
- Accept and transfer in the same cycle cannot occur: accept requires `hold_full=0` and transfer requires `hold_full=1`. A word accepted in the same cycle as a last-bit strobe waits for the next strobe.
- Bit order is fixed per word from its latched `Msb_First`. Changing the input mid-word has no effect.
- Reset (any time, including mid-word): both stored words are discarded.
  - `Data_Ready=1`, `Ser_Data=1`, `Ser_Active=0`, `Finish=0`.
  - `bit_cnt=0`; `shift_reg` and `hold_reg` are cleared to 0.

## Timing
- Accept at edge N sets `hold_full`. The first `Ser_En` edge at N+1 or later, with the FSM in IDLE, loads the word. Bit 0 appears on `Ser_Data` the cycle after that edge.
- With `Ser_En` tied high, a word accepted at edge N while idle has its first bit valid from cycle N+2 through N+2+W-1.
- Each bit is held until the next `Ser_En` edge, so bit period = strobe period.
- `Finish` is high for exactly one clock, in the cycle after the strobe that ends the last bit. In back-to-back operation it coincides with bit 0 of the next word.
- `Data_Ready` rises the cycle after a transfer. A sustained stream therefore loses no bit slots when the strobe period is ≥ 2 clocks or a word is pre-buffered.

## Structure
- A shared UART package holds the idle-line level constant (`1'b1`) and the `BIT_CNT_W = $clog2(P_DATA_WIDTH)` helper function.
- There are no sub-modules. The holding stage and shift stage are two always blocks in one module, estimated at about 150 lines.

## Test plan
- **LSB-first, Ser_En=1:** `P_Data=0x1E`, `Msb_First=0` → `Ser_Data` = 0,1,1,1,1,0,0,0. `Finish` pulses once, `Ser_Active` is high for 8 cycles, then `Ser_Data` returns to 1.
- **MSB-first:** `0x1E`, `Msb_First=1` → 0,0,0,1,1,1,1,0. Toggling `Msb_First` mid-word does not change the order.
- **Back-to-back:** `0xFF` then `0x00`, with the second word accepted during the first → 16 contiguous bits with no idle 1. `Finish` pulses after bit 8 and after bit 16; `Data_Ready` is low while the holding register is full.
- **Strobed:** `Ser_En` every 4th cycle, `0xA5` → each bit held for 4 clocks. `Finish` appears 1 cycle after the 8th-bit strobe.
- **Backpressure:** `Data_Valid` held high with 3 successive words while `Data_Ready` toggles → each word is transmitted exactly once, in order, with none dropped or duplicated.
- **Mid-word reset:** `Reset` asserted after bit 3 with a word pending → next cycle `Ser_Data=1`, `Ser_Active=0`, `Data_Ready=1`, `Finish=0`. The pending word is never sent; a new word is then serialised correctly.

Source files
------------

// File: rtl/buffered_serializer_pkg.sv
// Shared UART definitions: idle line level, serializer FSM states and the
// bit-counter width helper.
package buffered_serializer_pkg;

    // Level driven on the serial line whenever no data bit is being sent.
    localparam logic LINE_IDLE = 1'b1;

    // Shift-stage states: IDLE has no word in flight, SHIFT is sending one.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    // Width of a counter that indexes bits 0..width-1 of a data word.
    function automatic int bit_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/buffered_serializer_if.sv
// Handshake and serial-side signals between the UART TX frame FSM (master)
// and the buffered serializer (slave).
interface buffered_serializer_if #(
    parameter int P_DATA_WIDTH = 8
);
    logic [P_DATA_WIDTH-1:0] P_Data;
    logic                    Msb_First;
    logic                    Data_Valid;
    logic                    Data_Ready;
    logic                    Ser_En;
    logic                    Ser_Data;
    logic                    Ser_Active;
    logic                    Finish;

    // Frame FSM side: offers words, strobes bits, watches the serial line.
    modport master (
        output P_Data, Msb_First, Data_Valid, Ser_En,
        input  Data_Ready, Ser_Data, Ser_Active, Finish
    );

    // Serializer side.
    modport slave (
        input  P_Data, Msb_First, Data_Valid, Ser_En,
        output Data_Ready, Ser_Data, Ser_Active, Finish
    );
endinterface

// File: rtl/buffered_serializer.sv
// Double-buffered parallel-to-serial converter. A holding register accepts a
// word over valid/ready while the shift stage sends the previous one, so
// consecutive words leave back-to-back with no idle bit between them.
module buffered_serializer
    import buffered_serializer_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    buffered_serializer_if.slave  bus
);

    localparam int                    BIT_CNT_W = bit_cnt_w(P_DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0]  LAST_CNT  = BIT_CNT_W'(P_DATA_WIDTH - 1);

    // Holding stage
    logic [P_DATA_WIDTH-1:0] r_hold_reg;
    logic                    r_hold_msb;
    logic                    r_hold_full;

    // Shift stage
    logic [P_DATA_WIDTH-1:0] r_shift_reg;
    logic                    r_cur_msb;
    logic [BIT_CNT_W-1:0]    r_bit_cnt;
    logic                    r_ser_data;
    logic                    r_finish;
    ser_state_e              r_state;

    // Decoded controls
    ser_state_e              w_next_state;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_load;
    logic                    w_advance;
    logic                    w_finish_next;
    logic [P_DATA_WIDTH-1:0] w_shifted;

    assign w_accept  = bus.Data_Valid && !r_hold_full;
    assign w_last    = (r_bit_cnt == LAST_CNT);
    // Move the next bit toward whichever end the current word drains from.
    assign w_shifted = r_cur_msb ? (r_shift_reg << 1) : (r_shift_reg >> 1);

    // Next-state and datapath controls; nothing moves without a bit strobe.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_next_state  = r_state;
        w_load        = 1'b0;
        w_advance     = 1'b0;
        w_finish_next = 1'b0;
        if (bus.Ser_En) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_hold_full) begin
                        w_load       = 1'b1;
                        w_next_state = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!w_last) begin
                        w_advance = 1'b1;
                    end else begin
                        w_finish_next = 1'b1;
                        if (r_hold_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_next_state = ST_IDLE;
                        end
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        // NOTE: clocked blocks use non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Holding stage: accept a word when empty, release it to the shifter on load.
    always_ff @(posedge Clk) begin
        // NOTE: data registers are cleared on reset as well, so a reset
        // discards any pending word instead of leaving it to leak out later.
        if (Reset) begin
            r_hold_reg  <= '0;
            r_hold_msb  <= 1'b0;
            r_hold_full <= 1'b0;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_reg  <= bus.P_Data;
            r_hold_msb  <= bus.Msb_First;
            r_hold_full <= 1'b1;
        end
    end

    // Shift stage: load a word, step through its bits, return the line to idle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_shift_reg <= '0;
            r_cur_msb   <= 1'b0;
            r_bit_cnt   <= '0;
            r_ser_data  <= LINE_IDLE;
            r_finish    <= 1'b0;
        end else begin
            r_finish <= w_finish_next;
            if (w_load) begin
                r_shift_reg <= r_hold_reg;
                r_cur_msb   <= r_hold_msb;
                r_bit_cnt   <= '0;
                r_ser_data  <= r_hold_msb ? r_hold_reg[P_DATA_WIDTH-1] : r_hold_reg[0];
            end else if (w_advance) begin
                r_shift_reg <= w_shifted;
                r_bit_cnt   <= r_bit_cnt + BIT_CNT_W'(1);
                r_ser_data  <= r_cur_msb ? w_shifted[P_DATA_WIDTH-1] : w_shifted[0];
            end else if (w_finish_next) begin
                r_ser_data  <= LINE_IDLE;
            end
        end
    end

    assign bus.Data_Ready = !r_hold_full;
    assign bus.Ser_Data   = r_ser_data;
    assign bus.Ser_Active = (r_state == ST_SHIFT);
    assign bus.Finish     = r_finish;

endmodule

// File: tb/tb_buffered_serializer.sv
// Directed bench for buffered_serializer (8-bit words). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_buffered_serializer;

    logic Clk;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    buffered_serializer_if #(.P_DATA_WIDTH(8)) bus ();

    buffered_serializer #(.P_DATA_WIDTH(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send one word from idle with Ser_En tied high and check its bit stream,
    // the Finish pulse and the return to idle. Starts and ends at a negedge.
    task automatic send_word(input string tag, input logic [7:0] data, input logic msb,
                             input logic [0:7] stream, input logic toggle_msb);
        bus.P_Data     = data;
        bus.Msb_First  = msb;
        bus.Data_Valid = 1'b1;
        bus.Ser_En     = 1'b1;
        @(negedge Clk);
        bus.Data_Valid = 1'b0;
        check({tag, "/ready_low"}, bus.Data_Ready, 1'b0);
        check({tag, "/not_active_yet"}, bus.Ser_Active, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (toggle_msb) bus.Msb_First = ~bus.Msb_First;
            check($sformatf("%s/bit%0d", tag, i), bus.Ser_Data, stream[i]);
            check($sformatf("%s/active%0d", tag, i), bus.Ser_Active, 1'b1);
            check($sformatf("%s/nofinish%0d", tag, i), bus.Finish, 1'b0);
        end
        @(negedge Clk);
        check({tag, "/finish"}, bus.Finish, 1'b1);
        check({tag, "/active_off"}, bus.Ser_Active, 1'b0);
        check({tag, "/line_idle"}, bus.Ser_Data, 1'b1);
        check({tag, "/ready_back"}, bus.Data_Ready, 1'b1);
        @(negedge Clk);
        check({tag, "/finish_one_cycle"}, bus.Finish, 1'b0);
    endtask

    initial begin
        logic [0:15] b2b_stream;
        logic [0:7]  a5_stream;
        logic [0:7]  rst_stream;
        logic        bits_q[$];
        logic [7:0]  words[3];
        logic [7:0]  got;
        logic        acc;
        int          widx;
        int          fin_cnt;

        // ---------------- reset ----------------
        Reset          = 1'b1;
        bus.P_Data     = '0;
        bus.Msb_First  = 1'b0;
        bus.Data_Valid = 1'b0;
        bus.Ser_En     = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset/ready", bus.Data_Ready, 1'b1);
        check("reset/ser_data", bus.Ser_Data, 1'b1);
        check("reset/active", bus.Ser_Active, 1'b0);
        check("reset/finish", bus.Finish, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);

        // ---------------- LSB-first 0x1E ----------------
        send_word("lsb", 8'h1E, 1'b0, 8'b01111000, 1'b0);

        // ---------------- MSB-first 0x1E, Msb_First toggled mid-word --------
        send_word("msb", 8'h1E, 1'b1, 8'b00011110, 1'b1);

        // ---------------- back-to-back 0xFF then 0x00 ----------------
        b2b_stream     = 16'b1111_1111_0000_0000;
        bus.Msb_First  = 1'b0;
        bus.P_Data     = 8'hFF;
        bus.Data_Valid = 1'b1;
        bus.Ser_En     = 1'b1;
        @(negedge Clk);
        check("b2b/ready_low_first", bus.Data_Ready, 1'b0);
        bus.P_Data = 8'h00;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            check($sformatf("b2b/bit%0d", i), bus.Ser_Data, b2b_stream[i]);
            check($sformatf("b2b/active%0d", i), bus.Ser_Active, 1'b1);
            check($sformatf("b2b/finish%0d", i), bus.Finish, (i == 8));
            if (i == 0) check("b2b/ready_after_load", bus.Data_Ready, 1'b1);
            if (i == 1) begin
                check("b2b/ready_low_second", bus.Data_Ready, 1'b0);
                bus.Data_Valid = 1'b0;
            end
            if (i == 8) check("b2b/ready_after_second_load", bus.Data_Ready, 1'b1);
        end
        @(negedge Clk);
        check("b2b/final_finish", bus.Finish, 1'b1);
        check("b2b/active_off", bus.Ser_Active, 1'b0);
        check("b2b/line_idle", bus.Ser_Data, 1'b1);
        @(negedge Clk);

        // ---------------- strobed: Ser_En every 4th cycle, 0xA5 ----------------
        a5_stream      = 8'b10100101;
        bus.Ser_En     = 1'b0;
        bus.P_Data     = 8'hA5;
        bus.Data_Valid = 1'b1;
        @(negedge Clk);
        bus.Data_Valid = 1'b0;
        check("strobe/waiting_idle", bus.Ser_Active, 1'b0);
        bus.Ser_En = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("strobe/bit%0d_clk%0d", i, k), bus.Ser_Data, a5_stream[i]);
                check($sformatf("strobe/nofinish%0d_%0d", i, k), bus.Finish, 1'b0);
                bus.Ser_En = (k == 3);
                @(negedge Clk);
            end
        end
        check("strobe/finish", bus.Finish, 1'b1);
        check("strobe/line_idle", bus.Ser_Data, 1'b1);
        bus.Ser_En = 1'b0;
        @(negedge Clk);
        check("strobe/finish_one_cycle", bus.Finish, 1'b0);

        // ---------------- backpressure: 3 words, Data_Valid held high --------
        words          = '{8'h3C, 8'h81, 8'h6E};
        widx           = 0;
        fin_cnt        = 0;
        bus.Ser_En     = 1'b1;
        bus.Msb_First  = 1'b0;
        bus.P_Data     = words[0];
        bus.Data_Valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.Ser_Active) bits_q.push_back(bus.Ser_Data);
            if (bus.Finish) fin_cnt++;
            acc = bus.Data_Valid && bus.Data_Ready;
            @(posedge Clk);
            #1;
            if (acc) begin
                widx++;
                if (widx < 3) bus.P_Data = words[widx];
                else bus.Data_Valid = 1'b0;
            end
            @(negedge Clk);
        end
        check_val("bp/accepted", widx, 3);
        check_val("bp/bit_count", bits_q.size(), 24);
        check_val("bp/finish_count", fin_cnt, 3);
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 8; b++) begin
                got[b] = (8 * w + b < bits_q.size()) ? bits_q[8 * w + b] : 1'bx;
            end
            check_val($sformatf("bp/word%0d", w), int'(got), int'(words[w]));
        end

        // ---------------- mid-word reset with a word pending ----------------
        bus.Ser_En     = 1'b1;
        bus.Msb_First  = 1'b0;
        bus.P_Data     = 8'h55;
        bus.Data_Valid = 1'b1;
        @(negedge Clk);
        bus.P_Data = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (i == 1) begin
                check("rst/pending_held", bus.Data_Ready, 1'b0);
                bus.Data_Valid = 1'b0;
            end
        end
        check("rst/bit3", bus.Ser_Data, 1'b0);
        check("rst/active_before", bus.Ser_Active, 1'b1);
        Reset = 1'b1;
        @(negedge Clk);
        check("rst/ser_data", bus.Ser_Data, 1'b1);
        check("rst/active", bus.Ser_Active, 1'b0);
        check("rst/ready", bus.Data_Ready, 1'b1);
        check("rst/finish", bus.Finish, 1'b0);
        Reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            check($sformatf("rst/pending_dropped%0d", c), bus.Ser_Active, 1'b0);
        end
        rst_stream = 8'b11000011;
        send_word("after_rst", 8'hC3, 1'b1, rst_stream, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
